// File: rtl/apb3_requester_arbiter.sv
// Round-robin arbiter sharing one APB3 completer among NumRequesters APB3 requesters.
// Optional ACCESS-phase timeout is compiled in with `define APB3_ARB_TIMEOUT_EN.
module apb3_requester_arbiter #(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NumRequesters-1:0]             req_psel,
  input  logic [NumRequesters-1:0]             req_penable,
  input  logic [NumRequesters-1:0]             req_pwrite,
  input  logic [NumRequesters*AddressWidth-1:0] req_paddr,
  input  logic [NumRequesters*DataWidth-1:0]   req_pwdata,
  output logic [DataWidth-1:0]                 req_prdata,
  output logic [NumRequesters-1:0]             req_pready,
  output logic [NumRequesters-1:0]             req_pslverr,
  output logic [NumRequesters-1:0]             gnt,
  output logic                                 psel,
  output logic                                 penable,
  output logic                                 pwrite,
  output logic [AddressWidth-1:0]              paddr,
  output logic [DataWidth-1:0]                 pwdata,
  input  logic [DataWidth-1:0]                 prdata,
  input  logic                                 pready,
  input  logic                                 pslverr
);

  localparam int IdxW = $clog2(NumRequesters);

  if (NumRequesters < 2 || NumRequesters > 8 || TimeoutCycles < 1) begin : g_bad_param
    $error("apb3_requester_arbiter: NumRequesters must be 2..8 and TimeoutCycles >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                   state_reg, state_next;
  logic [IdxW-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [IdxW-1:0]          gnt_idx_reg, gnt_idx_next;
  logic [NumRequesters-1:0] gnt_reg, gnt_next;
  logic                     pwrite_reg, pwrite_next;
  logic [AddressWidth-1:0]  paddr_reg, paddr_next;
  logic [DataWidth-1:0]     pwdata_reg, pwdata_next;
  logic [DataWidth-1:0]     rdata_reg, rdata_next;
  logic                     err_reg, err_next;

`ifdef APB3_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0]          tmo_cnt_reg, tmo_cnt_next;
`endif

  logic [AddressWidth-1:0]  req_addr_arr  [NumRequesters];
  logic [DataWidth-1:0]     req_wdata_arr [NumRequesters];
  logic [IdxW-1:0]          pick;
  logic [NumRequesters-1:0] pick_onehot;

  for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_unpack
    assign req_addr_arr[gi]  = req_paddr[gi*AddressWidth +: AddressWidth];
    assign req_wdata_arr[gi] = req_pwdata[gi*DataWidth +: DataWidth];
    assign pick_onehot[gi]   = (pick == IdxW'(gi));
  end

  // Scan from the farthest candidate towards rr_ptr so the nearest requester wins.
  always_comb begin
    int cand;
    cand = 0;
    pick = rr_ptr_reg;
    for (int k = NumRequesters - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NumRequesters) cand = cand - NumRequesters;
      if (req_psel[cand]) pick = IdxW'(cand);
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    gnt_idx_next = gnt_idx_reg;
    gnt_next     = gnt_reg;
    pwrite_next  = pwrite_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
`ifdef APB3_ARB_TIMEOUT_EN
    tmo_cnt_next = tmo_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|req_psel) begin
          gnt_idx_next = pick;
          gnt_next     = pick_onehot;
          pwrite_next  = req_pwrite[pick];
          paddr_next   = req_addr_arr[pick];
          pwdata_next  = req_wdata_arr[pick];
          state_next   = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
`ifdef APB3_ARB_TIMEOUT_EN
        tmo_cnt_next = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          rdata_next = prdata;
          err_next   = pslverr;
          state_next = RESP;
        end
`ifdef APB3_ARB_TIMEOUT_EN
        // The last permitted wait cycle ends the transfer with an error.
        else if (tmo_cnt_reg == CntW'(TimeoutCycles - 1)) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end
      RESP: begin
        rr_ptr_next = (gnt_idx_reg == IdxW'(NumRequesters - 1)) ? '0 : gnt_idx_reg + 1'b1;
        gnt_next    = '0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      gnt_idx_reg <= '0;
      gnt_reg     <= '0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
`ifdef APB3_ARB_TIMEOUT_EN
      tmo_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      gnt_idx_reg <= gnt_idx_next;
      gnt_reg     <= gnt_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
`ifdef APB3_ARB_TIMEOUT_EN
      tmo_cnt_reg <= tmo_cnt_next;
`endif
    end
  end

  assign psel        = (state_reg == SETUP) || (state_reg == ACCESS);
  assign penable     = (state_reg == ACCESS);
  assign pwrite      = pwrite_reg;
  assign paddr       = paddr_reg;
  assign pwdata      = pwdata_reg;
  assign gnt         = gnt_reg;
  assign req_pready  = (state_reg == RESP) ? gnt_reg : '0;
  assign req_pslverr = (state_reg == RESP && err_reg) ? gnt_reg : '0;
  assign req_prdata  = (state_reg == RESP) ? rdata_reg : '0;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_reg));
  a_penable_needs_psel: assert property (@(posedge clk) disable iff (rst)
    ((req_penable & ~req_psel) == '0));

endmodule

// File: tb/tb_apb3_requester_arbiter.sv
// Directed self-checking bench for apb3_requester_arbiter (4 requesters, small memory completer).
module tb_apb3_requester_arbiter;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_psel, req_penable, req_pwrite;
  logic [N*AW-1:0] req_paddr;
  logic [N*DW-1:0] req_pwdata;
  logic [DW-1:0]   req_prdata;
  logic [N-1:0]    req_pready, req_pslverr, gnt;
  logic            psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata, prdata;

  int total = 0;
  int bad   = 0;

  // completer model
  logic [DW-1:0] mem [0:255];
  int  acc_cnt;
  int  waits = 0;
  bit  hang = 1'b0;
  bit  mem_clr = 1'b1;

  assign pready  = psel && penable && !hang && (acc_cnt >= waits);
  assign prdata  = mem[paddr[7:0]];
  assign pslverr = pready && (paddr == 20'hBAD00);

  always @(posedge clk) begin
    if (rst || !(psel && penable) || pready) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
    if (mem_clr) begin
      for (int j = 0; j < 256; j++) mem[j] <= '0;
    end else if (psel && penable && pready && pwrite) begin
      mem[paddr[7:0]] <= pwdata;
    end
  end

  always #5 clk = ~clk;

  apb3_requester_arbiter #(
    .NumRequesters(N), .AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_psel(req_psel), .req_penable(req_penable), .req_pwrite(req_pwrite),
    .req_paddr(req_paddr), .req_pwdata(req_pwdata),
    .req_prdata(req_prdata), .req_pready(req_pready), .req_pslverr(req_pslverr),
    .gnt(gnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_psel[i] = 1'b1;
    req_pwrite[i] = w;
    req_paddr[i*AW +: AW] = a;
    req_pwdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_psel = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int ncomp;
  int cnt  [N];
  int sent [N];
  logic [N-1:0] exp_gnt;

  initial begin
    rst = 1'b1;
    req_psel = '0; req_penable = '0; req_pwrite = '0;
    req_paddr = '0; req_pwdata = '0;
    tick();
    tick();
    mem_clr = 1'b0;
    rst = 1'b0;

    // reset state
    chk("rst_gnt", gnt, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_req_pready", req_pready, 0);
    chk("rst_req_pslverr", req_pslverr, 0);
    chk("rst_req_prdata", req_prdata, 0);
    $display("reset state checked");

    // single write then read by requester 0
    do_reset();
    set_req(0, 1'b1, 20'h00010, 32'hDEADBEEF);
    chk("wr_c0_psel", psel, 0);
    tick();
    chk("wr_c1_psel", psel, 1);
    chk("wr_c1_penable", penable, 0);
    chk("wr_c1_gnt", gnt, 4'b0001);
    chk("wr_c1_paddr", paddr, 20'h00010);
    chk("wr_c1_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_c1_pwrite", pwrite, 1);
    tick();
    chk("wr_c2_penable", penable, 1);
    tick();
    chk("wr_c3_req_pready", req_pready, 4'b0001);
    chk("wr_c3_req_pslverr", req_pslverr, 0);
    set_req(0, 1'b0, 20'h00010, 32'h0);
    tick();
    chk("rd_c4_psel", psel, 0);
    chk("rd_c4_req_pready", req_pready, 0);
    tick(); tick(); tick();
    chk("rd_c7_req_pready", req_pready, 4'b0001);
    chk("rd_c7_req_prdata", req_prdata, 32'hDEADBEEF);
    req_psel = '0;
    $display("write/read txn: addr=00010 data=%h", 32'hDEADBEEF);

    // simultaneous requests from reset
    do_reset();
    set_req(0, 1'b0, 20'h00010, 32'h0);
    set_req(1, 1'b0, 20'h00010, 32'h0);
    chk("sim_c0_gnt", gnt, 0);
    tick();
    chk("sim_c1_gnt", gnt, 4'b0001);
    tick(); tick();
    chk("sim_c3_req_pready", req_pready, 4'b0001);
    req_psel[0] = 1'b0;
    tick();
    chk("sim_c4_gnt", gnt, 0);
    tick();
    chk("sim_c5_gnt", gnt, 4'b0010);
    tick(); tick();
    chk("sim_c7_req_pready", req_pready, 4'b0010);
    chk("sim_c7_req_prdata", req_prdata, 32'hDEADBEEF);
    req_psel = '0;
    $display("simultaneous txn: r0 then r1 done");

    // completer error propagates to the granted requester only
    do_reset();
    set_req(1, 1'b0, 20'hBAD00, 32'h0);
    tick(); tick(); tick();
    chk("err_req_pready", req_pready, 4'b0010);
    chk("err_req_pslverr", req_pslverr, 4'b0010);
    req_psel = '0;
    $display("error txn: r1 addr=BAD00");

    // three wait states
    do_reset();
    waits = 3;
    set_req(2, 1'b1, 20'h00044, 32'h12345678);
    tick();
    chk("ws_c1_gnt", gnt, 4'b0100);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk($sformatf("ws_c%0d_penable", c), penable, 1);
      chk($sformatf("ws_c%0d_paddr", c), paddr, 20'h00044);
      chk($sformatf("ws_c%0d_pwdata", c), pwdata, 32'h12345678);
      chk($sformatf("ws_c%0d_req_pready", c), req_pready, 0);
    end
    tick();
    chk("ws_c6_req_pready", req_pready, 4'b0100);
    req_psel = '0;
    waits = 0;
    $display("wait-state txn: r2 completed at cycle 6");

    // continuous contention, 8 writes per requester
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      sent[i] = 0;
      set_req(i, 1'b1, AW'(64 + i*8), 32'hC0DE0000 | DW'(i << 8));
    end
    ncomp = 0;
    for (int cyc = 0; cyc < 400 && ncomp < 4*8; cyc++) begin
      tick();
      if (req_pready != '0) begin
        exp_gnt = N'(1 << (ncomp % N));
        chk($sformatf("rr_order_%0d", ncomp), req_pready, exp_gnt);
        for (int i = 0; i < N; i++) begin
          if (req_pready[i]) begin
            cnt[i]++;
            sent[i]++;
            if (sent[i] < 8) set_req(i, 1'b1, AW'(64 + i*8 + sent[i]), 32'hC0DE0000 | DW'((i << 8) | sent[i]));
            else req_psel[i] = 1'b0;
          end
        end
        ncomp++;
      end
    end
    chk("rr_completions", ncomp, 32);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rr_count_%0d", i), cnt[i], 8);
      chk($sformatf("rr_mem_%0d", i), mem[64 + i*8 + 7], 32'hC0DE0000 | DW'((i << 8) | 7));
    end
    req_psel = '0;
    $display("contention txn: %0d completions", ncomp);

    // reset during ACCESS
    do_reset();
    set_req(0, 1'b1, 20'h00020, 32'hA5A5A5A5);
    tick(); tick(); tick();
    chk("rda_first_req_pready", req_pready, 4'b0001);
    req_psel[0] = 1'b0;
    tick();
    waits = 3;
    set_req(1, 1'b1, 20'h00024, 32'h5A5A5A5A);
    tick(); tick();
    chk("rda_access_penable", penable, 1);
    chk("rda_access_gnt", gnt, 4'b0010);
    rst = 1'b1;
    req_psel = '0;
    tick();
    rst = 1'b0;
    waits = 0;
    chk("rda_psel", psel, 0);
    chk("rda_penable", penable, 0);
    chk("rda_gnt", gnt, 0);
    chk("rda_paddr", paddr, 0);
    chk("rda_pwdata", pwdata, 0);
    chk("rda_pwrite", pwrite, 0);
    chk("rda_req_pready", req_pready, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rda_quiet_%0d", c), req_pready, 0);
    end
    set_req(0, 1'b0, 20'h00020, 32'h0);
    set_req(1, 1'b0, 20'h00020, 32'h0);
    tick();
    chk("rda_ptr_zero_gnt", gnt, 4'b0001);
    tick(); tick();
    req_psel[0] = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rda_r1_req_pready", req_pready, 4'b0010);
    chk("rda_r1_req_prdata", req_prdata, 32'hA5A5A5A5);
    req_psel = '0;
    $display("reset-in-access txn: ptr back to 0");

    // completer that never answers
    do_reset();
    hang = 1'b1;
    set_req(0, 1'b0, 20'h00030, 32'h0);
    tick(); tick();
    chk("to_c2_penable", penable, 1);
`ifdef APB3_ARB_TIMEOUT_EN
    tick(); tick(); tick();
    chk("to_c5_penable", penable, 1);
    chk("to_c5_req_pready", req_pready, 0);
    tick();
    chk("to_c6_req_pready", req_pready, 4'b0001);
    chk("to_c6_req_pslverr", req_pslverr, 4'b0001);
    chk("to_c6_req_prdata", req_prdata, 0);
    chk("to_c6_psel", psel, 0);
    chk("to_c6_penable", penable, 0);
    $display("timeout txn: error response at cycle 6");
`else
    for (int c = 0; c < 100; c++) tick();
    chk("hang_psel", psel, 1);
    chk("hang_penable", penable, 1);
    chk("hang_gnt", gnt, 4'b0001);
    chk("hang_req_pready", req_pready, 0);
    $display("no-timeout txn: still in ACCESS after 100 cycles");
`endif
    hang = 1'b0;
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb3_requester_arbiter.md
# apb3_requester_arbiter

Round-robin arbiter that shares one APB3 completer (e.g. `apb3_completer_mem`) between `NumRequesters` APB3 requesters. It sits between the requesters, such as `apb3_requester_synth` instances or a Renode-driven `renode_apb3_if`, and a single completer. The arbiter re-issues each granted transfer on the completer side with its own SETUP/ACCESS sequence. It returns the completer's response only to the granted requester and stalls all others.

## Interface
- `NumRequesters`, 2: number of requester ports; legal range 2..8.
- `AddressWidth`, 20: APB3 address width.
- `DataWidth`, 32: APB3 data width.
- `TimeoutCycles`, 16: maximum ACCESS-phase length; used only when the timeout is compiled in.

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_psel` in `NumRequesters`: per-requester select.
- `req_penable` in `NumRequesters`: per-requester enable. It is ignored for sequencing and is only checked by assertions.
- `req_pwrite` in `NumRequesters`: per-requester write flag.
- `req_paddr` in `NumRequesters*AddressWidth`: packed addresses; requester i occupies bits [i*AW +: AW].
- `req_pwdata` in `NumRequesters*DataWidth`: packed write data.
- `req_prdata` out `DataWidth`: read data, broadcast to all requesters and qualified by `req_pready`.
- `req_pready` out `NumRequesters`: one-hot completion pulse.
- `req_pslverr` out `NumRequesters`: error flag, valid together with `req_pready`.
- `gnt` out `NumRequesters`: one-hot current grant; all zero in IDLE.
- `psel`, `penable`, `pwrite` out 1: completer-side controls.
- `paddr` out `AddressWidth`: completer-side address.
- `pwdata` out `DataWidth`: completer-side write data.
- `prdata` in `DataWidth`: completer read data.
- `pready` in 1: completer ready.
- `pslverr` in 1: completer error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any `req_psel` bit is set, select the first requester at or after `rr_ptr`, with wrap-around.
  - Latch that requester's `pwrite`, `paddr` and `pwdata` into the completer-side registers, set `gnt`, and go to SETUP.
  - With no request, stay in IDLE.
- SETUP: `psel`=1, `penable`=0; always go to ACCESS on the next cycle.
- ACCESS:
  - Drive `psel`=1, `penable`=1.
  - On `pready`=1, capture `prdata` and `pslverr` and go to RESP.
- RESP:
  - Drive `psel`=`penable`=0.
  - Drive `req_pready[g]`=1, `req_pslverr[g]`=captured error and `req_prdata`=captured data for this one cycle.
  - Set `rr_ptr` = (g+1) mod `NumRequesters`, clear `gnt`, and go to IDLE.
- Requesters must hold `psel`, `pwrite`, `paddr` and `pwdata` stable until their `req_pready`. Values are sampled only in IDLE, so later changes do not affect the completer side.
- Non-granted requesters see `req_pready`=0 indefinitely; their requests are never dropped.
- Simultaneous requests: the requester nearest `rr_ptr` (ascending, wrapping) wins. With all ports requesting continuously, grants rotate 0,1,…,N-1,0.
- `req_prdata` is 0 outside RESP. For writes it carries the captured `prdata` (don't-care).
- Address and data pass unmodified and at full width; no decoding.

## Timing
- Reset values: all outputs 0, `rr_ptr`=0, state IDLE.
- Reset asserted in any state forces the reset values at the next edge. An in-flight completer transfer is abandoned and no `req_pready` is issued.
- Latency: request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2 → RESP at cycle 3 with a zero-wait completer. Each wait state adds one cycle.
- Minimum period is 4 cycles per transfer. A requester re-asserting `psel` in the cycle after RESP is sampled in that IDLE cycle.
- `pready` is ignored outside ACCESS.

## Configuration
- `APB3_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When it reaches `TimeoutCycles`, the FSM goes to RESP with `req_pslverr[g]`=1 and `req_prdata`=0, and `psel`/`penable` drop at that same edge.
- `APB3_ARB_TIMEOUT_EN` undefined: no counter; ACCESS waits for `pready` indefinitely and `TimeoutCycles` is unused.

## Test plan
- Single write, then read: requester 0 writes 0xDEADBEEF to 0x00010, then reads it back. Required: completer `psel` in cycle 1, `penable` in cycle 2, `req_pready[0]` in cycle 3; `req_prdata`=0xDEADBEEF on the read; `req_pready[1]` stays 0.
- Simultaneous requests: both requesters issue at cycle 0 from reset. Required: requester 0 is served first and requester 1 completes 4 cycles later; `gnt` sequence 01, 00, 10.
- Continuous contention: N=4, all requesters issue 8 back-to-back writes. Required: grant order 0,1,2,3 repeating and exactly 8 completions per port.
- Wait states: completer holds `pready` low for 3 ACCESS cycles. Required: `req_pready` arrives at cycle 6 and completer address and data stay stable throughout ACCESS.
- Reset during ACCESS: assert `rst` for one cycle. Required: all outputs are 0 the next cycle, no `req_pready` pulse, and `rr_ptr` returns to 0.
- Timeout, with `APB3_ARB_TIMEOUT_EN` and `TimeoutCycles`=4: completer never asserts `pready`. Required: RESP with `req_pslverr`=1 and `req_prdata`=0 after 4 ACCESS cycles. Without the macro, the bench checks that the arbiter is still in ACCESS after 100 cycles.
